traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Sensor-driven green-time scheduler for an N-approach junction; shares one green between vehicle-sensor
//  requesters round-robin with min/max green, yellow and all-red clearance. Runs at 1 Hz (1 cycle = 1 s).
//  Phase 0 is the main-road default; it rests in green when nothing else requests. Drives lamp heads directly.
// PARAMETERS
//  NUM_PHASES  4   approaches/requesters (2..8)
//  MIN_GREEN   10  minimum green, cycles (>=1, <=MAX_GREEN)
//  MAX_GREEN   30  maximum green while others wait, cycles
//  YELLOW_T    3   yellow interval, cycles (>=1)
//  ALLRED_T    2   all-red clearance, cycles (>=1)
//  PED_T       8   pedestrian walk interval, cycles (PED_PHASE_EN only)
//  CNT_W       8   count width; all *_T/GREEN values < 2**CNT_W
// PORTS
//  clk           in   1             system clock, 1 Hz
//  rst           in   1             asynchronous, active-high reset
//  req           in   NUM_PHASES    level vehicle-sensor request per phase
//  lights        out  3*NUM_PHASES  lamps, phase p at [3p+2:3p]; 3'b100 red, 3'b010 yellow, 3'b001 green
//  active_phase  out  clog2(N)      phase owning current green/yellow, or next target during ALLRED
//  count         out  CNT_W         cycles remaining in current interval (down-counter)
//  ped_req       in   1             pedestrian button pulse (PED_PHASE_EN only)
//  ped_walk      out  1             walk lamp (PED_PHASE_EN only)
// BEHAVIOUR
//  - All outputs registered. States: GREEN, YELLOW, ALLRED (+PED). Reset: state ALLRED, count=ALLRED_T-1,
//    all lights red, active_phase=0, target=0, ped_walk=0, ped latch clear. Mid-operation rst: same, at once.
//  - count decrements each cycle; each state entry loads interval-1 (GREEN: MAX_GREEN-1). In GREEN it
//    saturates at 0 and green holds; YELLOW/ALLRED/PED exit on the cycle count==0.
//  - others = req with bit active_phase masked. min_ok = (count <= MAX_GREEN-MIN_GREEN).
//  - GREEN->YELLOW when gap_out = min_ok && !req[active] && (|others || active!=0),
//    or max_out = (count==0) && |others. Min green always shown exactly >= MIN_GREEN cycles.
//  - Target latched on GREEN->YELLOW: first set bit of others searching active+1 upward, wrapping;
//    if none, phase 0. req changes after latching do not alter target.
//  - YELLOW (active lamp yellow, rest red) -> ALLRED (all red, active_phase=target) -> GREEN on target.
//  - Own req held and no others: green persists indefinitely (no max_out).
//  - All non-active lamps are red at all times; never two non-red lamps.
// CONFIGURATION
//  PED_PHASE_EN defined: ped_req/ped_walk exist; ped_req sets sticky ped_pending (cleared on PED entry).
//   ped_pending counts as an "other" request for gap_out/max_out. After ALLRED, if ped_pending:
//   PED (all vehicle red, ped_walk=1, count=PED_T-1) -> ALLRED again -> GREEN on target.
//   ped_req during PED is latched for the next cycle of service.
//  PED_PHASE_EN undefined: no ped ports, no PED state, ped logic absent.
// STRUCTURE
//  traffic_pkg: lamp constants LT_RED/LT_YELLOW/LT_GREEN, state enum, rr_next function.
//  Sub-module phase_timer: loadable CNT_W down-counter with load value, zero flag, saturate-at-0.
//  Top holds FSM, target latch, round-robin search, lamp encode.
// TESTING
//  1 rst, req=0 -> 2 cycles all red, then phase0 green, count=29 down to 0, green held.
//  2 idle phase0 green, req=4'b0100 at cycle 3 of green -> phase0 green through cycle 10, 3 yellow,
//    2 all-red, phase2 green with count=29.
//  3 req=4'b1111 held -> greens exactly 30 cycles each, order 0,1,2,3,0; 5 cycles yellow+red between.
//  4 phase1 green, req=4'b1010, req[1] dropped after min -> next green phase3 (skips 2).
//  5 rst pulse during YELLOW of phase2 -> same cycle all red, active_phase=0, count=1; phase0 green after 2.
//  6 PED_PHASE_EN, phase0 green req=0, ped_req 1-cycle pulse -> yellow 3, red 2, ped_walk 8, red 2,
//    phase0 green.

Source files
------------

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared lamp encodings, controller state type and the round-robin target search
// used by the traffic phase scheduler.
package traffic_pkg;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_PED    = 2'd3
  } state_t;

  // First requesting phase after cur, wrapping around n phases; phase 0 when nobody asks.
  function automatic logic [2:0] rr_next(input logic [7:0] cand, input logic [2:0] cur,
                                         input int n);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k < 8; k++) begin
      idx = 3'((int'(cur) + k) % n);
      if (!found && (k < n) && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// Loadable interval down-counter; holds at zero until the next load.
module phase_timer #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= CNT_W'(RST_VAL);
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Round-robin green-time scheduler for an N-approach junction with min/max green and clearance.
// Define PED_PHASE_EN to add the pedestrian walk interval (ped_req / ped_walk ports).
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int MIN_GREEN  = 10,
  parameter int MAX_GREEN  = 30,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
`ifdef PED_PHASE_EN
  parameter int PED_T      = 8,
`endif
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         req,
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [CNT_W-1:0]              count
`ifdef PED_PHASE_EN
  ,
  input  logic                          ped_req,
  output logic                          ped_walk
`endif
);

  localparam int PW = $clog2(NUM_PHASES);

  state_t                  state, state_n;
  logic [PW-1:0]           target, target_n, active_n;
  logic [NUM_PHASES-1:0]   others;
  logic [3*NUM_PHASES-1:0] lights_n;
  logic [CNT_W-1:0]        tmr_val;
  logic                    tmr_load, tmr_zero;
  logic                    others_any, min_ok, gap_out, max_out, go_ped;

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_T - 1)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (count),
    .zero     (tmr_zero)
  );

  always_comb begin
    others               = req;
    others[active_phase] = 1'b0;
  end

`ifdef PED_PHASE_EN
  logic ped_pending, ped_done, ped_enter;

  assign ped_enter  = (state_n == ST_PED) && (state != ST_PED);
  assign others_any = (|others) || ped_pending;
  assign go_ped     = ped_pending && !ped_done;

  // ped_done marks the clearance after a walk so the walk is not repeated before a green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pending <= 1'b0;
      ped_done    <= 1'b0;
      ped_walk    <= 1'b0;
    end else begin
      ped_pending <= (ped_pending && !ped_enter) || ped_req;
      ped_walk    <= (state_n == ST_PED);
      if (state == ST_PED && state_n == ST_ALLRED)
        ped_done <= 1'b1;
      else if (state_n == ST_GREEN)
        ped_done <= 1'b0;
    end
  end
`else
  assign others_any = |others;
  assign go_ped     = 1'b0;
`endif

  assign min_ok  = (count <= CNT_W'(MAX_GREEN - MIN_GREEN));
  assign gap_out = min_ok && !req[active_phase] && (others_any || (active_phase != '0));
  assign max_out = tmr_zero && others_any;

  always_comb begin
    state_n  = state;
    target_n = target;
    active_n = active_phase;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_GREEN: begin
        if (gap_out || max_out) begin
          state_n  = ST_YELLOW;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(YELLOW_T - 1);
          target_n = PW'(rr_next(8'(others), 3'(active_phase), NUM_PHASES));
        end
      end
      ST_YELLOW: begin
        if (tmr_zero) begin
          state_n  = ST_ALLRED;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(ALLRED_T - 1);
          active_n = target;
        end
      end
      ST_ALLRED: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (go_ped) begin
            state_n = ST_PED;
`ifdef PED_PHASE_EN
            tmr_val = CNT_W'(PED_T - 1);
`endif
          end else begin
            state_n = ST_GREEN;
            tmr_val = CNT_W'(MAX_GREEN - 1);
          end
        end
      end
      ST_PED: begin
        if (tmr_zero) begin
          state_n  = ST_ALLRED;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(ALLRED_T - 1);
        end
      end
      default: state_n = ST_ALLRED;
    endcase
  end

  // Lamps are encoded from the next state so they change on the same edge as the state.
  always_comb begin
    lights_n = {NUM_PHASES{LT_RED}};
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (active_n == PW'(p)) begin
        if (state_n == ST_GREEN)
          lights_n[3*p +: 3] = LT_GREEN;
        else if (state_n == ST_YELLOW)
          lights_n[3*p +: 3] = LT_YELLOW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ALLRED;
      target       <= '0;
      active_phase <= '0;
      lights       <= {NUM_PHASES{LT_RED}};
    end else begin
      state        <= state_n;
      target       <= target_n;
      active_phase <= active_n;
      lights       <= lights_n;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: elapsed-time junction model checked
// every cycle, plus hand-computed checkpoints for each scenario.
module tb_traffic_phase_scheduler;

  localparam int NP   = 4;
  localparam int MING = 10;
  localparam int MAXG = 30;
  localparam int YT   = 3;
  localparam int ART  = 2;
  localparam int PT   = 8;
  localparam int CW   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP-1:0]   req = '0;
  logic [3*NP-1:0] lights;
  logic [1:0]      active_phase;
  logic [CW-1:0]   count;
`ifdef PED_PHASE_EN
  logic            ped_req = 1'b0;
  logic            ped_walk;
`endif

  int tests = 0;
  int fails = 0;

  traffic_phase_scheduler #(
    .NUM_PHASES (NP),
    .MIN_GREEN  (MING),
    .MAX_GREEN  (MAXG),
    .YELLOW_T   (YT),
    .ALLRED_T   (ART),
`ifdef PED_PHASE_EN
    .PED_T      (PT),
`endif
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .lights       (lights),
    .active_phase (active_phase),
    .count        (count)
`ifdef PED_PHASE_EN
    ,
    .ped_req      (ped_req),
    .ped_walk     (ped_walk)
`endif
  );

  always #5 clk = ~clk;

  // Model: mode 0 green, 1 yellow, 2 clearance, 3 walk; m_time = cycles already spent in mode.
  int m_mode, m_phase, m_next, m_time;
  bit m_ped, m_walked;

  task automatic modelReset();
    m_mode = 2; m_phase = 0; m_next = 0; m_time = 0; m_ped = 0; m_walked = 0;
  endtask

  task automatic modelStep(input logic [NP-1:0] r, input logic pr);
    bit any, leave, walk_start;
    int shown;
    any = m_ped;
    walk_start = 0;
    for (int p = 0; p < NP; p++)
      if (p != m_phase && r[p]) any = 1;
    case (m_mode)
      0: begin
        shown = m_time + 1;
        leave = (shown >= MING && !r[m_phase] && (any || m_phase != 0)) || (shown >= MAXG && any);
        if (leave) begin
          m_next = 0;
          for (int k = 1; k < NP; k++)
            if (r[(m_phase + k) % NP]) begin
              m_next = (m_phase + k) % NP;
              break;
            end
          m_mode = 1; m_time = 0;
        end else m_time++;
      end
      1: if (m_time + 1 >= YT) begin m_mode = 2; m_phase = m_next; m_time = 0; end else m_time++;
      2: if (m_time + 1 >= ART) begin
           if (m_ped && !m_walked) begin m_mode = 3; walk_start = 1; end
           else begin m_mode = 0; m_walked = 0; end
           m_time = 0;
         end else m_time++;
      default: if (m_time + 1 >= PT) begin m_mode = 2; m_walked = 1; m_time = 0; end else m_time++;
    endcase
    m_ped = (m_ped && !walk_start) || pr;
  endtask

  function automatic int modelCount();
    case (m_mode)
      0: return (MAXG - 1 - m_time > 0) ? MAXG - 1 - m_time : 0;
      1: return YT - 1 - m_time;
      2: return ART - 1 - m_time;
      default: return PT - 1 - m_time;
    endcase
  endfunction

  function automatic logic [3*NP-1:0] modelLights();
    logic [3*NP-1:0] l;
    l = {NP{3'b100}};
    if (m_mode == 0) l[3*m_phase +: 3] = 3'b001;
    else if (m_mode == 1) l[3*m_phase +: 3] = 3'b010;
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [3*NP-1:0] el, input int ea, input int ec);
    tests++;
    if (lights !== el || active_phase !== 2'(ea) || count !== 8'(ec)) begin
      fails++;
      $display("[TB] FAIL %s: got lights=%h active=%0d count=%0d, expected lights=%h active=%0d count=%0d",
               name, lights, active_phase, count, el, ea, ec);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Compare process: advance the model on each edge, check on the falling edge.
  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      if (rst) modelReset();
`ifdef PED_PHASE_EN
      else modelStep(req, ped_req);
`else
      else modelStep(req, 1'b0);
`endif
      @(negedge clk);
      if (rst) modelReset();
      checkOutput($sformatf("model@%0t", $time), modelLights(), m_phase, modelCount());
`ifdef PED_PHASE_EN
      checkValue($sformatf("model_walk@%0t", $time), int'(ped_walk), int'(m_mode == 3));
`endif
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NP-1:0] r);
    req = r;
  endtask

  function automatic int greenPhase();
    for (int p = 0; p < NP; p++)
      if (lights[3*p +: 3] == 3'b001) return p;
    return -1;
  endfunction

  task automatic waitGreenOther(input string name, input int avoid, input int budget, output int ph);
    ph = -1;
    for (int i = 0; i < budget; i++) begin
      nextCycle();
      if (greenPhase() >= 0 && greenPhase() != avoid) begin
        ph = greenPhase();
        break;
      end
    end
    if (ph < 0) begin
      tests++; fails++;
      $display("[TB] FAIL %s: timeout waiting for green, got none, expected a green within %0d cycles",
               name, budget);
    end
  endtask

  int ph, len, gap;
  bit seen;

  initial begin
    // Reset then idle: two clearance cycles, phase 0 green resting at zero.
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_state", 12'h924, 0, 1);
    nextCycle(); checkOutput("allred_second", 12'h924, 0, 0);
    nextCycle(); checkOutput("green0_entry", 12'h921, 0, 29);
    repeat (35) nextCycle();
    checkOutput("green0_saturate", 12'h921, 0, 0);

    // Phase 2 requests on the third green cycle: minimum green still honoured.
    rst = 1'b1;
    #1 checkOutput("rst_async", 12'h924, 0, 1);
    nextCycle(); rst = 1'b0;
    nextCycle(); nextCycle(); checkOutput("t2_green_c1", 12'h921, 0, 29);
    nextCycle(); nextCycle(); applyStimulus(4'b0100);
    repeat (7) nextCycle(); checkOutput("t2_min_green_end", 12'h921, 0, 20);
    nextCycle(); checkOutput("t2_yellow", 12'h922, 0, 2);
    repeat (2) nextCycle(); checkOutput("t2_yellow_end", 12'h922, 0, 0);
    nextCycle(); checkOutput("t2_allred_target", 12'h924, 2, 1);
    nextCycle(); nextCycle(); checkOutput("t2_green2", 12'h864, 2, 29);

    // Reach phase 1, then gap out to phase 3 skipping idle phase 2.
    applyStimulus(4'b0010);
    waitGreenOther("t4_wait_p1", 2, 40, ph); checkValue("t4_reach_p1", ph, 1);
    applyStimulus(4'b1010);
    repeat (12) nextCycle();
    applyStimulus(4'b1000);
    waitGreenOther("t4_wait_p3", 1, 40, ph); checkValue("t4_skip_to_p3", ph, 3);

    // All phases requesting: max-out greens of 30, 5-cycle changeover, strict rotation.
    applyStimulus(4'b1111);
    waitGreenOther("t3_wait_p0", 3, 60, ph); checkValue("t3_order_0", ph, 0);
    len = 0;
    while (greenPhase() == 0 && len < 100) begin len++; nextCycle(); end
    checkValue("t3_green_len", len, 30);
    gap = 0;
    while (greenPhase() < 0 && gap < 50) begin gap++; nextCycle(); end
    checkValue("t3_changeover", gap, 5);
    checkValue("t3_order_1", greenPhase(), 1);

    // Reset during phase 2 yellow.
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      nextCycle();
      if (lights[8:6] == 3'b010) begin seen = 1; break; end
    end
    checkValue("t5_reach_yellow2", int'(seen), 1);
    rst = 1'b1;
    #1 checkOutput("t5_rst_in_yellow", 12'h924, 0, 1);
    nextCycle(); rst = 1'b0;
    nextCycle(); checkOutput("t5_allred", 12'h924, 0, 0);
    nextCycle(); checkOutput("t5_green0", 12'h921, 0, 29);

`ifdef PED_PHASE_EN
    // Pedestrian button while phase 0 rests green.
    applyStimulus(4'b0000);
    repeat (12) nextCycle();
    ped_req = 1'b1;
    nextCycle(); ped_req = 1'b0;
    checkOutput("t6_green_hold", 12'h921, 0, 16);
    nextCycle(); checkOutput("t6_yellow", 12'h922, 0, 2);
    repeat (2) nextCycle();
    nextCycle(); checkOutput("t6_allred1", 12'h924, 0, 1);
    nextCycle();
    nextCycle(); checkOutput("t6_walk_start", 12'h924, 0, 7);
    checkValue("t6_walk_on", int'(ped_walk), 1);
    repeat (7) nextCycle(); checkOutput("t6_walk_end", 12'h924, 0, 0);
    nextCycle(); checkOutput("t6_allred2", 12'h924, 0, 1);
    checkValue("t6_walk_off", int'(ped_walk), 0);
    nextCycle(); nextCycle(); checkOutput("t6_green0", 12'h921, 0, 29);
`endif

    repeat (5) nextCycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
